// File: rtl/rob_if.sv
// rob_if: dispatch, CDB, commit and status signals of the reorder buffer.
interface rob_if #(parameter int IDX_W = 5, parameter int DATA_W = 32);
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [IDX_W-1:0]  alloc_idx_o;
  logic [DATA_W-1:0] alloc_pc_i;
  logic [4:0]        alloc_rd_i;
  logic              alloc_rd_we_i;
  logic              cdb_en_i;
  logic [IDX_W-1:0]  cdb_tag_i;
  logic [DATA_W-1:0] cdb_data_i;
  logic              commit_valid_o;
  logic              commit_ready_i;
  logic [IDX_W-1:0]  commit_idx_o;
  logic [DATA_W-1:0] commit_pc_o;
  logic [4:0]        commit_rd_o;
  logic              commit_rd_we_o;
  logic [DATA_W-1:0] commit_data_o;
  logic              flush_i;
  logic              empty_o;
  logic [IDX_W:0]    count_o;
  modport master (
    output alloc_valid_i, alloc_pc_i, alloc_rd_i, alloc_rd_we_i, cdb_en_i, cdb_tag_i, cdb_data_i,
           commit_ready_i, flush_i,
    input  alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o, commit_pc_o, commit_rd_o,
           commit_rd_we_o, commit_data_o, empty_o, count_o
  );
  modport slave (
    input  alloc_valid_i, alloc_pc_i, alloc_rd_i, alloc_rd_we_i, cdb_en_i, cdb_tag_i, cdb_data_i,
           commit_ready_i, flush_i,
    output alloc_ready_o, alloc_idx_o, commit_valid_o, commit_idx_o, commit_pc_o, commit_rd_o,
           commit_rd_we_o, commit_data_o, empty_o, count_o
  );
endinterface

// File: rtl/rob.sv
// rob: reorder buffer; allocates in order, captures CDB results, retires in program order.
module rob #(
  parameter int ROB_SIZE = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input logic clk_i,
  input logic reset_i,
  rob_if.slave bus
);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ROB_SIZE);
  logic [IDX_W:0]    r_head, r_tail;
  logic [ROB_SIZE-1:0] r_valid, r_done, r_rd_we;
  logic [DATA_W-1:0] r_pc [ROB_SIZE];
  logic [DATA_W-1:0] r_data [ROB_SIZE];
  logic [4:0]        r_rd [ROB_SIZE];
  logic [IDX_W:0]    w_count;
  logic [IDX_W-1:0]  w_head, w_tail;
  logic              w_full, w_alloc, w_cdb, w_cv, w_commit;
  assign w_count  = r_tail - r_head;
  assign w_head   = r_head[IDX_W-1:0];
  assign w_tail   = r_tail[IDX_W-1:0];
  assign w_full   = w_count == FULL;
  assign w_alloc  = bus.alloc_valid_i & ~w_full;
  // a CDB aimed at the slot being allocated this cycle loses to the allocation
  assign w_cdb    = bus.cdb_en_i & r_valid[bus.cdb_tag_i] & ~r_done[bus.cdb_tag_i] &
                    ~(w_alloc & (bus.cdb_tag_i == w_tail));
  assign w_cv     = r_valid[w_head] & r_done[w_head];
  assign w_commit = w_cv & bus.commit_ready_i;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (bus.flush_i) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_cdb) r_done[bus.cdb_tag_i] <= 1'b1;
      if (w_commit) begin
        r_valid[w_head] <= 1'b0;
        r_done[w_head]  <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[w_tail] <= 1'b1;
        r_done[w_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
    end
  end
  // payload needs no reset: it is only observed through valid/done
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_pc[w_tail]    <= bus.alloc_pc_i;
      r_rd[w_tail]    <= bus.alloc_rd_i;
      r_rd_we[w_tail] <= bus.alloc_rd_we_i;
      r_data[w_tail]  <= '0;
    end
    if (w_cdb) r_data[bus.cdb_tag_i] <= bus.cdb_data_i;
  end
  assign bus.alloc_ready_o  = ~w_full;
  assign bus.alloc_idx_o    = w_tail;
  assign bus.commit_valid_o = w_cv;
  assign bus.commit_idx_o   = w_head;
  assign bus.commit_pc_o    = w_cv ? r_pc[w_head] : '0;
  assign bus.commit_rd_o    = w_cv ? r_rd[w_head] : '0;
  assign bus.commit_rd_we_o = w_cv & r_rd_we[w_head];
  assign bus.commit_data_o  = w_cv ? r_data[w_head] : '0;
  assign bus.empty_o        = w_count == '0;
  assign bus.count_o        = w_count;
endmodule

// File: doc/rob.md
Name: rob

Overview:
Reorder buffer. Sits between dispatch and the reservation stations / register-file writeback.
- Allocates one entry per dispatched instruction. The entry index is the rob_idx carried through the reservation station and functional units.
- Captures results broadcast on the CDB.
- Retires entries strictly in program order to the architectural register file.

Parameters:
ROB_SIZE, 32, number of entries (power of two)
IDX_W, 5, index width, log2(ROB_SIZE)
DATA_W, 32, result/PC width

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_i  in  1  reset, asynchronous, active-high
alloc_valid_i  in  1  dispatch requests one entry this cycle
alloc_ready_o  out  1  an entry is free (count_o < ROB_SIZE)
alloc_idx_o  out  IDX_W  index granted to the current allocation (tail)
alloc_pc_i  in  DATA_W  PC of the dispatched instruction
alloc_rd_i  in  5  architectural destination register
alloc_rd_we_i  in  1  instruction writes rd
cdb_en_i  in  1  completion broadcast valid
cdb_tag_i  in  IDX_W  ROB index of the completing instruction
cdb_data_i  in  DATA_W  result value
commit_valid_o  out  1  head entry is complete and retirable
commit_ready_i  in  1  register file accepts the retirement
commit_idx_o  out  IDX_W  head index
commit_pc_o  out  DATA_W  head PC
commit_rd_o  out  5  head destination register
commit_rd_we_o  out  1  head writes rd
commit_data_o  out  DATA_W  head result
flush_i  in  1  synchronous squash of all entries
empty_o  out  1  no valid entries
count_o  out  IDX_W+1  number of valid entries

Behaviour:
- Pointers: head_ptr and tail_ptr, each IDX_W+1 bits with an extra wrap bit.
  - count_o = tail_ptr - head_ptr (modulo 2^(IDX_W+1)).
  - Full when count_o == ROB_SIZE; empty_o = (count_o == 0).
  - Low IDX_W bits index storage and wrap from ROB_SIZE-1 to 0.
- Per-entry state: valid, done, pc, rd, rd_we, data.
- alloc_idx_o = tail_ptr[IDX_W-1:0], combinational. It is valid whenever alloc_ready_o = 1.
- Allocation fires when alloc_valid_i & alloc_ready_o at a clock edge. It sets:
  - entry[tail]: valid=1, done=0, pc/rd/rd_we from inputs, data=0
  - tail_ptr += 1
- alloc_valid_i while full is ignored: no state change.
- alloc_ready_o is derived from the current count only. There is no same-cycle bypass from a commit; a full ROB refuses allocation even in a cycle that commits.
- CDB capture: if cdb_en_i and entry[cdb_tag_i].valid and !done, then at the edge done=1 and data=cdb_data_i.
  - A CDB to an invalid entry is ignored.
  - A CDB to an already-done entry is ignored; the first result is kept.
- Commit:
  - commit_valid_o = entry[head].valid & entry[head].done, combinational from registered state.
  - A CDB to the head is therefore visible on commit_valid_o one cycle later (latency 1).
  - Retirement fires when commit_valid_o & commit_ready_i at an edge: entry[head].valid=0, done=0, head_ptr += 1.
  - While commit_ready_i = 0 the head holds and the commit outputs stay stable.
  - When commit_valid_o = 0, all commit_* data outputs are driven 0; commit_idx_o still shows the head index.
- Simultaneous events:
  - Allocation, CDB and commit may all occur in one cycle. The count changes by (alloc - commit).
  - An allocation into an index being retired in the same cycle is impossible, because full blocks allocation.
  - A CDB whose tag equals the entry being allocated in the same cycle is ignored; the allocation wins.
- Flush: flush_i=1 at an edge clears every valid/done bit and sets head_ptr = tail_ptr = 0.
  - Flush has priority over allocation, CDB and commit in that cycle.
  - Data fields need not be cleared.
- Reset: asserting reset_i immediately (asynchronously) clears all valid/done bits and head_ptr = tail_ptr = 0. Resulting outputs:
  - alloc_ready_o=1, alloc_idx_o=0
  - commit_valid_o=0, commit_idx_o=0, commit_pc_o=0, commit_rd_o=0, commit_rd_we_o=0, commit_data_o=0
  - empty_o=1, count_o=0
  - Reset asserted mid-operation discards all in-flight entries with no partial commit.

Test Plan:
- In-order retirement of out-of-order completions:
  - Stimulus: reset; allocate 3 (pc 0x100/0x104/0x108, rd 1/2/3) with commit_ready_i=1; CDB tag 2 data 0xC, then tag 0 data 0xA, then tag 1 data 0xB.
  - Required: alloc_idx_o 0,1,2; count_o 3. Commit of idx0 (rd1, 0xA) one cycle after its CDB, then idx1 (0xB), then idx2 (0xC); empty_o=1 at the end.
- Full and wrap:
  - Stimulus: allocate 32 with no CDB; then commit one entry; then allocate again.
  - Required: alloc_ready_o=0 at count_o=32 and further alloc_valid_i has no effect. After completing and committing idx0, alloc_ready_o=1 the next cycle and the next allocation receives idx0 (wrap).
- Commit backpressure:
  - Stimulus: head done, commit_ready_i=0 for 3 cycles, then 1.
  - Required: commit_valid_o=1 held with stable pc/rd/data for those 3 cycles; head_ptr advances on the first cycle with commit_ready_i=1.
- Ignored CDBs:
  - Stimulus: CDB tag 7 while entry 7 is free; CDB a second time (data 0x2) to an entry already done with data 0x1.
  - Required: no state change; the committed data stays 0x1.
- Flush priority:
  - Stimulus: 5 valid entries; in one cycle flush_i=1 together with alloc_valid_i=1, a CDB and commit_ready_i=1.
  - Required: next cycle count_o=0, empty_o=1, alloc_idx_o=0, commit_valid_o=0.
- Asynchronous reset:
  - Stimulus: assert reset_i between clock edges with 4 entries valid.
  - Required: outputs reach reset values before the next edge (count_o=0, commit_valid_o=0); after deassertion the first allocation receives idx0.
